// File: rtl/sram_access_arbiter.sv
// Two-port round-robin access controller for the standby-gated 8192x32 SRAM.
// Issues one registered access per cycle and sequences the standby handshake.
module sram_access_arbiter #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sleep_req,
    output logic          sleep_ack,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_ad,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] a_mask,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_ad,
    input  logic [DW-1:0] b_wdata,
    input  logic [DW-1:0] b_mask,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          sram_gate_mem,
    output logic          sram_n_cs,
    output logic          sram_n_we,
    output logic [DW-1:0] sram_mask,
    output logic [AW-1:0] sram_ad,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        STANDBY,
        WAKE
    } state_t;

    state_t state, state_nxt;

    logic rr_a;
    logic iss_b;
    logic can_gnt;
    logic pipe_empty;
    logic g_we;
    logic [AW-1:0] g_ad;
    logic [DW-1:0] g_wdata;
    logic [DW-1:0] g_mask;

    // sleep_req blocks grants in the very cycle it is first seen
    assign can_gnt = (state == ACTIVE) && !sleep_req && !reset;
    assign a_gnt = can_gnt && a_req && (!b_req || rr_a);
    assign b_gnt = can_gnt && b_req && (!a_req || !rr_a);

    assign g_we    = a_gnt ? a_we    : b_we;
    assign g_ad    = a_gnt ? a_ad    : b_ad;
    assign g_wdata = a_gnt ? a_wdata : b_wdata;
    assign g_mask  = a_gnt ? a_mask  : b_mask;

    assign pipe_empty = sram_n_cs && !a_rvalid && !b_rvalid;

    assign sleep_ack     = (state == STANDBY);
    assign sram_gate_mem = (state == STANDBY);

    assign a_rdata = a_rvalid ? sram_dout : '0;
    assign b_rdata = b_rvalid ? sram_dout : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACTIVE:  if (sleep_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!sleep_req)     state_nxt = ACTIVE;
                else if (pipe_empty) state_nxt = STANDBY;
            end
            STANDBY: if (!sleep_req) state_nxt = WAKE;
            WAKE:    state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACTIVE;
            rr_a      <= 1'b1;
            iss_b     <= 1'b0;
            sram_n_cs <= 1'b1;
            sram_n_we <= 1'b1;
            sram_mask <= '1;
            sram_ad   <= '0;
            sram_din  <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (a_gnt) rr_a <= 1'b0;
            if (b_gnt) rr_a <= 1'b1;
            if (a_gnt || b_gnt) begin
                sram_n_cs <= 1'b0;
                sram_n_we <= ~g_we;
                sram_mask <= g_we ? g_mask : '1;
                sram_ad   <= g_ad;
                sram_din  <= g_wdata;
                iss_b     <= b_gnt;
            end else begin
                sram_n_cs <= 1'b1;
                sram_n_we <= 1'b1;
                sram_mask <= '1;
            end
            a_rvalid <= !sram_n_cs && sram_n_we && !iss_b;
            b_rvalid <= !sram_n_cs && sram_n_we && iss_b;
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized and directed bench for sram_access_arbiter against
// a transaction-level model with a behavioural SRAM.
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sleep_req = 1'b0;
    logic        sleep_ack;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [12:0] a_ad = '0;
    logic [31:0] a_wdata = '0, a_mask = '0;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [12:0] b_ad = '0;
    logic [31:0] b_wdata = '0, b_mask = '0;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic        sram_gate_mem, sram_n_cs, sram_n_we;
    logic [31:0] sram_mask, sram_din;
    logic [12:0] sram_ad;
    logic [31:0] sram_dout = '0;

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .sleep_req(sleep_req), .sleep_ack(sleep_ack),
        .a_req(a_req), .a_we(a_we), .a_ad(a_ad),
        .a_wdata(a_wdata), .a_mask(a_mask),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_ad(b_ad),
        .b_wdata(b_wdata), .b_mask(b_mask),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_gate_mem(sram_gate_mem), .sram_n_cs(sram_n_cs),
        .sram_n_we(sram_n_we), .sram_mask(sram_mask),
        .sram_ad(sram_ad), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    // behavioural SRAM: masked write, read data the cycle after
    logic [31:0] mem [0:8191];
    always @(posedge clk) begin
        if (!sram_n_cs) begin
            if (!sram_n_we)
                mem[sram_ad] <= (mem[sram_ad] & sram_mask) | (sram_din & ~sram_mask);
            else
                sram_dout <= mem[sram_ad];
        end
    end

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] refm [0:8191];
    bit          pri_a = 1'b1;
    bit          blocked = 1'b0;
    bit          want_sleep = 1'b0;
    bit          ga_last = 1'b0, gb_last = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic set_a(input bit r, input bit w, input int ad, input logic [31:0] d, input logic [31:0] m);
        a_req = r; a_we = w; a_ad = 13'(ad); a_wdata = d; a_mask = m;
    endtask

    task automatic set_b(input bit r, input bit w, input int ad, input logic [31:0] d, input logic [31:0] m);
        b_req = r; b_we = w; b_ad = 13'(ad); b_wdata = d; b_mask = m;
    endtask

    // one cycle: compare against the model, then advance it
    task automatic tick();
        bit eg_a, eg_b, ev_a, ev_b;
        #1;
        eg_a = !blocked && a_req && (!b_req || pri_a);
        eg_b = !blocked && b_req && (!a_req || !pri_a);
        chk("a_gnt", a_gnt, eg_a);
        chk("b_gnt", b_gnt, eg_b);
        chk("sleep_ack", sleep_ack, want_sleep);
        chk("gate_mem", sram_gate_mem, want_sleep);
        if (want_sleep) chk("n_cs_stby", sram_n_cs, 1);
        ev_a = pend.size() > 0 && pend[0].due == cyc && pend[0].port == 1'b0;
        ev_b = pend.size() > 0 && pend[0].due == cyc && pend[0].port == 1'b1;
        chk("a_rvalid", a_rvalid, ev_a);
        chk("b_rvalid", b_rvalid, ev_b);
        if (ev_a) chk("a_rdata", a_rdata, pend[0].data);
        if (ev_b) chk("b_rdata", b_rdata, pend[0].data);
        if (ev_a || ev_b) void'(pend.pop_front());
        if (eg_a) begin
            pri_a = 1'b0;
            if (a_we) refm[a_ad] = (refm[a_ad] & a_mask) | (a_wdata & ~a_mask);
            else pend.push_back('{cyc + 2, 1'b0, refm[a_ad]});
        end
        if (eg_b) begin
            pri_a = 1'b1;
            if (b_we) refm[b_ad] = (refm[b_ad] & b_mask) | (b_wdata & ~b_mask);
            else pend.push_back('{cyc + 2, 1'b1, refm[b_ad]});
        end
        ga_last = eg_a;
        gb_last = eg_b;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sleep_req = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
        end
        chk("rst_n_cs", sram_n_cs, 1);
        chk("rst_n_we", sram_n_we, 1);
        chk("rst_mask", sram_mask, 32'hFFFF_FFFF);
        chk("rst_ad", sram_ad, 0);
        chk("rst_din", sram_din, 0);
        chk("rst_gate", sram_gate_mem, 0);
        chk("rst_ack", sleep_ack, 0);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        reset = 1'b0;
        pend.delete();
        pri_a = 1'b1;
        blocked = 1'b0;
        want_sleep = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i] = '0;
            refm[i] = '0;
        end
        do_reset();

        // reset then immediate A request
        set_a(1, 0, 'h20, 0, 0);
        tick();
        set_a(0, 0, 0, 0, 0);
        tick(); tick();

        // read after write on A
        set_a(1, 1, 'h10, 32'hDEADBEEF, 0);
        tick();
        set_a(1, 0, 'h10, 0, '1);
        tick();
        set_a(0, 0, 0, 0, 0);
        tick(); tick();

        // masked write at the top address, read back on B
        set_a(1, 1, 'h1FFF, 32'hFFFFFFFF, 0);
        tick();
        set_a(1, 1, 'h1FFF, 32'h0, 32'hFFFF0000);
        tick();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 0, 'h1FFF, 0, 0);
        tick();
        set_b(0, 0, 0, 0, 0);
        tick(); tick();

        // round robin with both held high
        set_a(1, 0, 'h10, 0, 0);
        set_b(1, 0, 'h1FFF, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // sleep with a B read in flight
        set_b(1, 0, 'h1FFF, 0, 0);
        tick();
        set_b(0, 0, 0, 0, 0);
        sleep_req = 1'b1;
        blocked = 1'b1;
        tick(); tick(); tick();
        want_sleep = 1'b1;
        set_a(1, 0, 'h10, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        sleep_req = 1'b0;
        tick();
        want_sleep = 1'b0;
        tick();
        blocked = 1'b0;
        tick();
        set_a(0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // reset with a read in flight
        set_a(1, 0, 'h10, 0, 0);
        tick();
        do_reset();
        set_a(1, 0, 'h1FFF, 0, 0);
        tick();
        set_a(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!a_req || ga_last)
                set_a($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15), $urandom,
                      $urandom_range(0, 3) == 0 ? $urandom : 0);
            if (!b_req || gb_last)
                set_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15), $urandom,
                      $urandom_range(0, 3) == 0 ? $urandom : 0);
            tick();
        end
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("pend_empty", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Two-port access controller for the 8192 x 32 standby-gated SRAM wrapper in the SRAM subsystem. It arbitrates round-robin between two requesters, a CPU-side port A and a DMA-side port B, and issues at most one registered SRAM access per cycle. Read data returns with fixed latency. It also sequences the standby handshake: it drains in-flight accesses, then asserts the wrapper's gate input, and releases it on wake.

## Interface
Parameters:
- AW, 13, SRAM address width (word address).
- DW, 32, data and mask width.

Ports:
- clk  input  1  posedge clock; all state is on this edge.
- reset  input  1  synchronous, active-high reset.
- sleep_req  input  1  standby request from the power controller; level.
- sleep_ack  output  1  high while the SRAM is gated.
- a_req  input  1  port A request; held until a_gnt.
- a_we  input  1  1=write, 0=read.
- a_ad  input  AW  port A word address.
- a_wdata  input  DW  port A write data.
- a_mask  input  DW  port A write mask; a 1 bit is not written.
- a_gnt  output  1  port A request accepted this cycle.
- a_rvalid  output  1  port A read data valid.
- a_rdata  output  DW  port A read data.
- b_req, b_we, b_ad, b_wdata, b_mask, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- sram_gate_mem  output  1  to the wrapper gate input.
- sram_n_cs  output  1  active-low select.
- sram_n_we  output  1  0=write.
- sram_mask  output  DW  to the SRAM mask input.
- sram_ad  output  AW  to the SRAM address input.
- sram_din  output  DW  to the SRAM data input.
- sram_dout  input  DW  SRAM read data, valid the cycle after the access edge.

## Operation
- FSM states: ACTIVE, DRAIN, STANDBY, WAKE. Reset enters ACTIVE.
- Reset values of all outputs:
  - sram_n_cs=1, sram_n_we=1, sram_mask=all ones, sram_ad=0, sram_din=0.
  - sram_gate_mem=0, sleep_ack=0.
  - a_gnt, b_gnt, a_rvalid, b_rvalid = 0; a_rdata, b_rdata = 0.
  - Round-robin pointer points to A (A wins the first tie).
- ACTIVE, grant:
  - gnt is combinational from req in the same cycle.
  - At most one of a_gnt and b_gnt is high in any cycle.
  - When only one port requests, it is granted.
  - When both request, the port not granted most recently wins. The pointer updates only on a grant.
- ACTIVE, issue: on a grant, the issue register loads the access.
  - sram_n_cs=0, sram_n_we=~we, sram_ad=ad, sram_din=wdata.
  - sram_mask = mask for writes, all ones for reads.
  - An issued read tags the owner port.
  - With no grant, the issue register returns to idle: n_cs=1, n_we=1, mask all ones. ad and din hold.
- Read return: the tagged port sees rvalid=1 with rdata=sram_dout for exactly one cycle. The other port's rvalid stays 0.
- Writes are posted and produce no response.
- ACTIVE -> DRAIN when sleep_req=1.
  - No grant is given in the cycle sleep_req is first seen.
  - A request already granted in the same cycle is not possible, because sleep_req blocks the grant.
- DRAIN:
  - No grants.
  - Moves to STANDBY once the issue stage and the read-return stage are both empty; in-flight reads still return.
  - If sleep_req drops while in DRAIN, move to ACTIVE.
- STANDBY:
  - sram_gate_mem=1 and sleep_ack=1, registered, asserted on entry.
  - SRAM outputs are idle and no grants are given.
  - Moves to WAKE when sleep_req=0.
- WAKE:
  - gate_mem=0 and sleep_ack=0 from entry.
  - No grant for this one cycle, then ACTIVE.
- Reset mid-operation: pending reads are discarded (no rvalid), the FSM returns to ACTIVE and gate_mem goes to 0.

## Timing
- Cycle N: req high and gnt high.
- Cycle N+1: SRAM pins carry the access; the SRAM samples at the end of N+1.
- Cycle N+2: rvalid and rdata for a read.
- Read latency is 2 cycles from grant. Sustained throughput is 1 access per cycle, including back-to-back alternating ports.
- A requester must keep req and its fields stable until gnt, and may change them in the cycle after gnt.
- Sleep entry:
  - With the pipeline empty, sleep_ack rises 2 cycles after sleep_req rises: ACTIVE, then DRAIN, then STANDBY.
  - Each cycle of pipeline occupancy adds one cycle to that delay.
- Wake: sleep_req falls in cycle M. WAKE is cycle M+1, and the first grant can occur in cycle M+2.

## Test plan
- Reset: assert reset for 2 cycles -> every output at its reset value; a_req=1 in the first cycle after reset -> a_gnt=1.
- Read-after-write, port A:
  - Write ad=0x0010, wdata=0xDEADBEEF, mask=0.
  - Then read ad=0x0010 -> a_rvalid=1 exactly 2 cycles after the read grant, with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Mask:
  - Write 0xFFFFFFFF to ad=0x1FFF, then write 0x00000000 with mask=0xFFFF0000.
  - Read back -> 0xFFFF0000.
- Round-robin: a_req and b_req held high for 6 cycles -> grants A,B,A,B,A,B; reads of known addresses return to the correct port in order.
- Sleep with a read in flight:
  - Grant a B read, and raise sleep_req in the next cycle.
  - Required: b_rvalid still occurs, then sleep_ack=1 and sram_gate_mem=1.
  - a_req held high during STANDBY is never granted.
  - Drop sleep_req -> a_gnt 2 cycles later.
  - Read data written before sleep is unchanged.
- Reset while a read is in flight -> no rvalid follows, and the FSM is in ACTIVE.
